// File: rtl/sd_block_responder.sv
// Target side of the hps_io sector protocol: serves one 256-word sector per sd_rd/sd_wr from a word-wide store.
// Optional feature macro SD_BLOCK_CHECKSUM_EN adds blk_sum, the mod-2^16 sum of the last sector's words.
module sd_block_responder #(
  parameter int AW      = 16,
  parameter int DIN_LAT = 2
) (
  input  logic          clk_sys,
  input  logic          reset,
  input  logic [31:0]   sd_lba,
  input  logic          sd_rd,
  input  logic          sd_wr,
  output logic          sd_ack,
  output logic [7:0]    sd_buff_addr,
  output logic [15:0]   sd_buff_dout,
  input  logic [15:0]   sd_buff_din,
  output logic          sd_buff_wr,
  output logic [AW-1:0] mem_addr,
  output logic          mem_rd,
  output logic          mem_wr,
  output logic [15:0]   mem_dout,
  input  logic [15:0]   mem_din,
  input  logic          mem_ready,
  output logic          busy,
  output logic          blk_done
`ifdef SD_BLOCK_CHECKSUM_EN
  ,
  output logic [15:0]   blk_sum
`endif
);

  typedef enum logic [3:0] {
    S_IDLE, S_ACK, S_RD_REQ, S_RD_WAIT, S_RD_PUT,
    S_WR_ADDR, S_WR_SETTLE, S_WR_REQ, S_WR_WAIT, S_DONE
  } state_t;

  localparam logic [2:0] SETTLE_LAST = 3'(DIN_LAT - 1);

  state_t        state, state_nxt;
  logic          op_rd;
  logic [AW-9:0] lba_q;
  logic [7:0]    word_idx;
  logic [2:0]    settle_cnt;
  logic          req_accept;
  logic          last_word;
  logic          settle_end;

  // Sector bits above the store's address range are deliberately dropped.
  logic unused_lba_hi;
  assign unused_lba_hi = ^sd_lba[31:AW-8];

  assign req_accept = (sd_rd | sd_wr) & ~sd_ack;
  assign last_word  = (word_idx == 8'hFF);
  assign settle_end = (settle_cnt == SETTLE_LAST);
  assign mem_addr   = {lba_q, word_idx};

  always_ff @(posedge clk_sys) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:      if (req_accept) state_nxt = S_ACK;
      S_ACK:       state_nxt = op_rd ? S_RD_REQ : S_WR_ADDR;
      S_RD_REQ:    state_nxt = S_RD_WAIT;
      S_RD_WAIT:   if (mem_ready) state_nxt = S_RD_PUT;
      S_RD_PUT:    state_nxt = last_word ? S_DONE : S_RD_REQ;
      S_WR_ADDR:   state_nxt = S_WR_SETTLE;
      S_WR_SETTLE: if (settle_end) state_nxt = S_WR_REQ;
      S_WR_REQ:    state_nxt = S_WR_WAIT;
      S_WR_WAIT:   if (mem_ready) state_nxt = last_word ? S_DONE : S_WR_ADDR;
      S_DONE:      state_nxt = S_IDLE;
      default:     state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    mem_rd     = (state == S_RD_REQ);
    mem_wr     = (state == S_WR_REQ);
    sd_buff_wr = (state == S_RD_PUT);
    busy       = (state != S_IDLE);
  end

  // Word datapath: sd_buff_addr moves on the edge into RD_PUT / WR_ADDR so it is stable for the whole word.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      op_rd        <= 1'b0;
      lba_q        <= '0;
      word_idx     <= '0;
      settle_cnt   <= '0;
      sd_ack       <= 1'b0;
      blk_done     <= 1'b0;
      sd_buff_addr <= '0;
      sd_buff_dout <= '0;
      mem_dout     <= '0;
    end else begin
      blk_done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (req_accept) begin
            lba_q    <= sd_lba[AW-9:0];
            op_rd    <= sd_rd;
            word_idx <= '0;
          end
        end
        S_ACK: begin
          sd_ack <= 1'b1;
          if (!op_rd) sd_buff_addr <= 8'd0;
        end
        S_RD_WAIT: begin
          if (mem_ready) begin
            sd_buff_addr <= word_idx;
            sd_buff_dout <= mem_din;
          end
        end
        S_RD_PUT: begin
          if (!last_word) word_idx <= word_idx + 8'd1;
        end
        S_WR_ADDR: settle_cnt <= '0;
        S_WR_SETTLE: begin
          settle_cnt <= settle_cnt + 3'd1;
          if (settle_end) mem_dout <= sd_buff_din;
        end
        S_WR_WAIT: begin
          if (mem_ready && !last_word) begin
            word_idx     <= word_idx + 8'd1;
            sd_buff_addr <= word_idx + 8'd1;
          end
        end
        S_DONE: begin
          sd_ack   <= 1'b0;
          blk_done <= 1'b1;
        end
        default: ;
      endcase
    end
  end

`ifdef SD_BLOCK_CHECKSUM_EN
  function automatic logic [15:0] sum_wrap(input logic [15:0] acc, input logic [15:0] word);
    return acc + word;
  endfunction

  // Running sector sum, accumulated at the same points where words are captured.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      blk_sum <= '0;
    end else if (state == S_ACK) begin
      blk_sum <= '0;
    end else if (state == S_RD_WAIT && mem_ready) begin
      blk_sum <= sum_wrap(blk_sum, mem_din);
    end else if (state == S_WR_SETTLE && settle_end) begin
      blk_sum <= sum_wrap(blk_sum, sd_buff_din);
    end
  end
`endif

endmodule

// File: tb/tb_sd_block_responder.sv
// Self-checking bench for sd_block_responder: memory/dpram models, monitors and a linear directed/random sequence.
module tb_sd_block_responder;
  localparam int AW      = 16;
  localparam int DIN_LAT = 2;

  logic          clk_sys;
  logic          reset;
  logic [31:0]   sd_lba;
  logic          sd_rd;
  logic          sd_wr;
  logic          sd_ack;
  logic [7:0]    sd_buff_addr;
  logic [15:0]   sd_buff_dout;
  logic [15:0]   sd_buff_din;
  logic          sd_buff_wr;
  logic [AW-1:0] mem_addr;
  logic          mem_rd;
  logic          mem_wr;
  logic [15:0]   mem_dout;
  logic [15:0]   mem_din;
  logic          mem_ready;
  logic          busy;
  logic          blk_done;
`ifdef SD_BLOCK_CHECKSUM_EN
  logic [15:0]   blk_sum;
`endif

  sd_block_responder #(.AW(AW), .DIN_LAT(DIN_LAT)) dut (
    .clk_sys(clk_sys), .reset(reset), .sd_lba(sd_lba), .sd_rd(sd_rd), .sd_wr(sd_wr),
    .sd_ack(sd_ack), .sd_buff_addr(sd_buff_addr), .sd_buff_dout(sd_buff_dout),
    .sd_buff_din(sd_buff_din), .sd_buff_wr(sd_buff_wr), .mem_addr(mem_addr),
    .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_dout(mem_dout), .mem_din(mem_din),
    .mem_ready(mem_ready), .busy(busy), .blk_done(blk_done)
`ifdef SD_BLOCK_CHECKSUM_EN
    , .blk_sum(blk_sum)
`endif
  );

  initial clk_sys = 1'b0;
  always #5 clk_sys = ~clk_sys;

  // Reference contents: backing store (read by the memory model) and core dpram.
  logic [15:0] store    [0:65535];
  logic [15:0] core_mem [0:255];

  int total = 0;
  int bad   = 0;
  int mem_lat  = 2;
  bit lat_rand = 1'b0;
  int stray_req = 0;
  int stray_srv = 0;

  // Monitor logs, written only by the monitor process.
  logic [15:0] rd_addr_q[$];
  logic [15:0] rd_data_q[$];
  logic [15:0] memrd_q[$];
  logic [15:0] wr_addr_q[$];
  logic [15:0] wr_data_q[$];
  int done_cnt = 0, rise_cnt = 0, done_at_fall = 0, hold_err = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Memory model: one outstanding access, ready pulse mem_lat cycles after the strobe cycle.
  initial begin
    logic [15:0] a;
    bit          is_rd;
    int          lat;
    mem_ready = 1'b0;
    mem_din   = '0;
    forever begin
      @(posedge clk_sys); #1;
      if (mem_rd || mem_wr) begin
        a     = mem_addr;
        is_rd = mem_rd;
        lat   = lat_rand ? int'($urandom_range(1, 3)) : mem_lat;
        repeat (lat) begin @(posedge clk_sys); #1; end
        mem_ready = 1'b1;
        mem_din   = is_rd ? store[a] : 16'h0BAD;
        @(posedge clk_sys); #1;
        mem_ready = 1'b0;
      end else if (stray_req != stray_srv) begin
        mem_ready = 1'b1;
        mem_din   = 16'($urandom);
        @(posedge clk_sys); #1;
        mem_ready = 1'b0;
        stray_srv++;
      end
    end
  end

  // Core dpram with a DIN_LAT-cycle registered read path.
  initial begin
    logic [15:0] pipe [DIN_LAT];
    logic [7:0]  addr_prev;
    for (int i = 0; i < DIN_LAT; i++) pipe[i] = '0;
    addr_prev   = '0;
    sd_buff_din = '0;
    forever begin
      @(posedge clk_sys); #1;
      for (int i = DIN_LAT - 1; i > 0; i--) pipe[i] = pipe[i-1];
      pipe[0]     = core_mem[addr_prev];
      addr_prev   = sd_buff_addr;
      sd_buff_din = pipe[DIN_LAT-1];
    end
  end

  initial begin
    logic       prev_ack, prev_wr;
    logic [7:0] prev_addr;
    logic [15:0] prev_dout;
    prev_ack = 1'b0; prev_wr = 1'b0; prev_addr = '0; prev_dout = '0;
    forever begin
      @(negedge clk_sys);
      if (sd_buff_wr) begin
        rd_addr_q.push_back({8'h00, sd_buff_addr});
        rd_data_q.push_back(sd_buff_dout);
      end
      if (prev_wr && (sd_buff_addr !== prev_addr || sd_buff_dout !== prev_dout)) hold_err++;
      if (mem_rd) memrd_q.push_back(mem_addr);
      if (mem_wr) begin
        wr_addr_q.push_back(mem_addr);
        wr_data_q.push_back(mem_dout);
      end
      if (blk_done) done_cnt++;
      if (blk_done && prev_ack && !sd_ack) done_at_fall++;
      if (sd_ack && !prev_ack) rise_cnt++;
      prev_ack  = sd_ack;
      prev_wr   = sd_buff_wr;
      prev_addr = sd_buff_addr;
      prev_dout = sd_buff_dout;
    end
  end

  function automatic logic [15:0] model_sum(input bit is_load, input logic [7:0] lba);
    logic [15:0] s;
    s = '0;
    for (int n = 0; n < 256; n++) s += is_load ? store[{lba, 8'(n)}] : core_mem[n];
    return s;
  endfunction

  task automatic do_sector(input bit rd, input bit wr, input logic [7:0] lba);
    int n;
    @(negedge clk_sys);
    sd_lba = {24'h0, lba};
    sd_rd  = rd;
    sd_wr  = wr;
    n = 0;
    while (sd_ack !== 1'b1 && n < 50) begin @(negedge clk_sys); n++; end
    sd_rd = 1'b0;
    sd_wr = 1'b0;
    check("ack_rise", sd_ack, 1'b1);
    n = 0;
    while (blk_done !== 1'b1 && n < 8000) begin @(negedge clk_sys); n++; end
    check("blk_done_seen", blk_done, 1'b1);
    @(negedge clk_sys);
  endtask

  task automatic verify(input bit is_load, input logic [7:0] lba,
                        input int rd0, input int m0, input int w0, input int d0);
    logic [7:0] w;
    if (is_load) begin
      check("ld_count", 32'(rd_addr_q.size() - rd0), 256);
      check("ld_memrd_count", 32'(memrd_q.size() - m0), 256);
      check("ld_no_memwr", 32'(wr_addr_q.size() - w0), 0);
      if (rd_addr_q.size() - rd0 == 256 && memrd_q.size() - m0 == 256)
        for (int n = 0; n < 256; n++) begin
          w = 8'(n);
          check("ld_addr", rd_addr_q[rd0+n], {8'h00, w});
          check("ld_dout", rd_data_q[rd0+n], store[{lba, w}]);
          check("ld_memaddr", memrd_q[m0+n], {lba, w});
        end
    end else begin
      check("sv_count", 32'(wr_addr_q.size() - w0), 256);
      check("sv_no_put", 32'(rd_addr_q.size() - rd0), 0);
      if (wr_addr_q.size() - w0 == 256)
        for (int n = 0; n < 256; n++) begin
          w = 8'(n);
          check("sv_memaddr", wr_addr_q[w0+n], {lba, w});
          check("sv_data", wr_data_q[w0+n], core_mem[n]);
        end
    end
    check("blk_done_cnt", 32'(done_cnt - d0), 1);
`ifdef SD_BLOCK_CHECKSUM_EN
    check("blk_sum", blk_sum, model_sum(is_load, lba));
`endif
  endtask

  initial begin
    int rd0, m0, w0, d0, r0, f0, rdr, n;
    bit op;
    logic [7:0] lba;
    reset = 1'b1; sd_rd = 1'b0; sd_wr = 1'b0; sd_lba = '0;
    for (int i = 0; i < 256; i++) core_mem[i] = '0;
    repeat (3) @(posedge clk_sys);
    @(negedge clk_sys);
    check("rst_ack", sd_ack, 0);
    check("rst_busy", busy, 0);
    check("rst_buff_wr", sd_buff_wr, 0);
    check("rst_mem_rd", mem_rd, 0);
    check("rst_mem_wr", mem_wr, 0);
    check("rst_blk_done", blk_done, 0);
    check("rst_buff_addr", sd_buff_addr, 0);
    check("rst_buff_dout", sd_buff_dout, 0);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_mem_dout", mem_dout, 0);
    reset = 1'b0;

    // Load lba 3, store word n = A500+n, fixed latency 2.
    for (int i = 0; i < 256; i++) store[{8'd3, 8'(i)}] = 16'hA500 + 16'(i);
    mem_lat = 2;
    rd0 = rd_addr_q.size(); m0 = memrd_q.size(); w0 = wr_addr_q.size(); d0 = done_cnt;
    do_sector(1'b1, 1'b0, 8'd3);
    verify(1'b1, 8'd3, rd0, m0, w0, d0);

    // Save lba 5, core word n = 1000+n.
    for (int i = 0; i < 256; i++) core_mem[i] = 16'h1000 + 16'(i);
    rd0 = rd_addr_q.size(); m0 = memrd_q.size(); w0 = wr_addr_q.size(); d0 = done_cnt;
    do_sector(1'b0, 1'b1, 8'd5);
    verify(1'b0, 8'd5, rd0, m0, w0, d0);

    // Both requests high: load wins; then a stray mem_ready in IDLE.
    for (int i = 0; i < 256; i++) store[{8'd9, 8'(i)}] = 16'($urandom);
    rd0 = rd_addr_q.size(); m0 = memrd_q.size(); w0 = wr_addr_q.size(); d0 = done_cnt;
    do_sector(1'b1, 1'b1, 8'd9);
    verify(1'b1, 8'd9, rd0, m0, w0, d0);
    rd0 = rd_addr_q.size();
    stray_req++;
    repeat (5) @(negedge clk_sys);
    check("stray_busy", busy, 0);
    check("stray_ack", sd_ack, 0);
    check("stray_no_put", 32'(rd_addr_q.size() - rd0), 0);
    check("stray_dout", sd_buff_dout, store[16'h09FF]);
    check("stray_addr", sd_buff_addr, 8'hFF);
    check("stray_mem_addr", mem_addr, 16'h09FF);

    // Reset while word 100 of a load is outstanding.
    for (int i = 0; i < 256; i++) store[{8'd7, 8'(i)}] = 16'($urandom);
    mem_lat = 3;
    m0 = memrd_q.size();
    @(negedge clk_sys);
    sd_lba = 32'd7; sd_rd = 1'b1;
    n = 0;
    while (sd_ack !== 1'b1 && n < 50) begin @(negedge clk_sys); n++; end
    sd_rd = 1'b0;
    check("rstx_ack_rise", sd_ack, 1);
    n = 0;
    while (memrd_q.size() - m0 < 101 && n < 3000) begin @(negedge clk_sys); n++; end
    check("rstx_reached_w100", 32'(memrd_q.size() - m0 >= 101), 1);
    reset = 1'b1;
    @(posedge clk_sys); #1;
    check("rstx_ack", sd_ack, 0);
    check("rstx_buff_wr", sd_buff_wr, 0);
    check("rstx_mem_rd", mem_rd, 0);
    check("rstx_mem_wr", mem_wr, 0);
    check("rstx_busy", busy, 0);
    @(negedge clk_sys);
    reset = 1'b0;
    rdr = rd_addr_q.size();
    repeat (8) @(negedge clk_sys);
    check("rstx_late_ready_ignored", 32'(rd_addr_q.size() - rdr), 0);
    check("rstx_idle", busy, 0);
    check("rstx_buff_dout", sd_buff_dout, 0);
    rd0 = rd_addr_q.size(); m0 = memrd_q.size(); w0 = wr_addr_q.size(); d0 = done_cnt;
    do_sector(1'b1, 1'b0, 8'd7);
    verify(1'b1, 8'd7, rd0, m0, w0, d0);

    // Back-to-back sectors lba 0..15, random direction, random memory latency.
    lat_rand = 1'b1;
    for (int s = 0; s < 16; s++)
      for (int i = 0; i < 256; i++) store[{8'(s), 8'(i)}] = 16'($urandom);
    d0 = done_cnt; r0 = rise_cnt; f0 = done_at_fall;
    for (int s = 0; s < 16; s++) begin
      op = 1'($urandom_range(0, 1));
      for (int i = 0; i < 256; i++) core_mem[i] = 16'($urandom);
      rd0 = rd_addr_q.size(); m0 = memrd_q.size(); w0 = wr_addr_q.size(); n = done_cnt;
      do_sector(op, ~op, 8'(s));
      verify(op, 8'(s), rd0, m0, w0, n);
    end
    check("ms_done", 32'(done_cnt - d0), 16);
    check("ms_ack_rises", 32'(rise_cnt - r0), 16);
    check("ms_done_at_ack_fall", 32'(done_at_fall - f0), 16);

    // A few random sectors with random data and lba.
    for (int s = 0; s < 4; s++) begin
      op  = 1'($urandom_range(0, 1));
      lba = 8'($urandom_range(16, 255));
      for (int i = 0; i < 256; i++) begin
        store[{lba, 8'(i)}] = 16'($urandom);
        core_mem[i]         = 16'($urandom);
      end
      rd0 = rd_addr_q.size(); m0 = memrd_q.size(); w0 = wr_addr_q.size(); d0 = done_cnt;
      do_sector(op, ~op, lba);
      verify(op, lba, rd0, m0, w0, d0);
    end

    // All-ones load: the sector sum wraps to FF00.
    for (int i = 0; i < 256; i++) store[{8'd11, 8'(i)}] = 16'hFFFF;
    rd0 = rd_addr_q.size(); m0 = memrd_q.size(); w0 = wr_addr_q.size(); d0 = done_cnt;
    do_sector(1'b1, 1'b0, 8'd11);
    verify(1'b1, 8'd11, rd0, m0, w0, d0);
`ifdef SD_BLOCK_CHECKSUM_EN
    check("blk_sum_ff00", blk_sum, 16'hFF00);
`endif

    check("buff_hold_after_put", hold_err, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "bench timeout");
  end
endmodule
